// File: rtl/aes_enc_core_if.sv
// Request/response bundle of the iterative AES encryption core: block start, plaintext,
// round-key handshake towards the key schedule, status and ciphertext.
interface aes_enc_core_if;
    logic         start;
    logic [3:0]   nr;
    logic [0:127] plain_in;
    logic [0:127] round_key;
    logic         round_key_valid;
    logic         key_req;
    logic [3:0]   round_idx;
    logic         busy;
    logic         done;
    logic         err;
    logic [0:127] cipher_out;

    modport master (
        output start, nr, plain_in, round_key, round_key_valid,
        input  key_req, round_idx, busy, done, err, cipher_out
    );

    modport slave (
        input  start, nr, plain_in, round_key, round_key_valid,
        output key_req, round_idx, busy, done, err, cipher_out
    );
endinterface

// File: rtl/aes_enc_core.sv
// Iterative AES encryptor, one round per ARK+SB pass; done 2*Nr+2 cycles after start (3*Nr+2 with
// AES_ENC_SBOX_PIPE_EN, which registers the S-box output); stalls in ARK while round_key_valid is low.
module aes_enc_core #(
    parameter logic [3:0] NR_DEFAULT = 4'd10
) (
    input logic           clk,
    input logic           rst,
    aes_enc_core_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARK, SB, DONE} state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [0:127] subBytes(input logic [0:127] s);
        logic [0:127] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = SBOX[s[8*i +: 8]];
        return r;
    endfunction

    // Bytes are column-major: byte (row + 4*col); row r rotates left by r.
    function automatic logic [0:127] shiftRows(input logic [0:127] s);
        logic [0:127] r;
        r = '0;
        for (int row = 0; row < 4; row++)
            for (int col = 0; col < 4; col++)
                r[8*(row + 4*col) +: 8] = s[8*(row + 4*((col + row) % 4)) +: 8];
        return r;
    endfunction

    function automatic logic [0:127] mixColumns(input logic [0:127] s);
        logic [0:127] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c +: 8];
            a1 = s[32*c + 8 +: 8];
            a2 = s[32*c + 16 +: 8];
            a3 = s[32*c + 24 +: 8];
            r[32*c +: 8]      = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[32*c + 8 +: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    state_t       stateQ, stateD;
    logic [0:127] aesState;
    logic [0:127] cipherQ;
    logic [3:0]   nrQ;
    logic [3:0]   roundIdxQ;
    logic         errQ;
    logic         keyReq, busyC, doneC;
`ifdef AES_ENC_SBOX_PIPE_EN
    logic         sbStage;
`endif

    logic [3:0]   nrEff;
    logic         nrLegal, startOk, lastRound, keyTake;
    logic [0:127] arkOut;

    assign nrEff     = (bus.nr == 4'd0) ? NR_DEFAULT : bus.nr;
    assign nrLegal   = (nrEff == 4'd10) || (nrEff == 4'd12) || (nrEff == 4'd14);
    assign startOk   = (stateQ == IDLE) && bus.start && nrLegal;
    assign lastRound = (roundIdxQ == nrQ);
    assign keyTake   = (stateQ == ARK) && bus.round_key_valid;
    // First and last AddRoundKey bypass MixColumns.
    assign arkOut    = (((roundIdxQ == 4'd0) || lastRound) ? aesState : mixColumns(aesState)) ^ bus.round_key;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stateQ <= IDLE;
        else      stateQ <= stateD;
    end

    always_comb begin
        stateD = stateQ;
        keyReq = 1'b0;
        busyC  = 1'b0;
        doneC  = 1'b0;
        case (stateQ)
            IDLE: if (startOk) stateD = ARK;
            ARK: begin
                keyReq = 1'b1;
                busyC  = 1'b1;
                if (bus.round_key_valid) stateD = lastRound ? DONE : SB;
            end
            SB: begin
                busyC = 1'b1;
`ifdef AES_ENC_SBOX_PIPE_EN
                if (sbStage) stateD = ARK;
`else
                stateD = ARK;
`endif
            end
            DONE: begin
                doneC  = 1'b1;
                stateD = IDLE;
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aesState  <= '0;
            cipherQ   <= '0;
            nrQ       <= '0;
            roundIdxQ <= '0;
            errQ      <= 1'b0;
`ifdef AES_ENC_SBOX_PIPE_EN
            sbStage   <= 1'b0;
`endif
        end else begin
            errQ <= (stateQ == IDLE) && bus.start && !nrLegal;
            case (stateQ)
                IDLE: if (startOk) begin
                    aesState  <= bus.plain_in;
                    nrQ       <= nrEff;
                    roundIdxQ <= 4'd0;
                end
                ARK: if (keyTake) begin
                    if (lastRound) cipherQ <= arkOut;
                    else begin
                        aesState  <= arkOut;
                        roundIdxQ <= roundIdxQ + 4'd1;
                    end
                end
                SB: begin
`ifdef AES_ENC_SBOX_PIPE_EN
                    // Two-step round reuses aesState as the S-box output register.
                    aesState <= sbStage ? shiftRows(aesState) : subBytes(aesState);
                    sbStage  <= !sbStage;
`else
                    aesState <= shiftRows(subBytes(aesState));
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.key_req    = keyReq;
    assign bus.busy       = busyC;
    assign bus.done       = doneC;
    assign bus.err        = errQ;
    assign bus.round_idx  = roundIdxQ;
    assign bus.cipher_out = cipherQ;
endmodule

// File: doc/aes_enc_core.md
Name: aes_enc_core

Overview:
Iterative AES encryption engine, the forward-direction counterpart of the decryption round datapath. Takes one 128-bit plaintext block and performs the initial AddRoundKey, then Nr rounds of SubBytes/ShiftRows/MixColumns/AddRoundKey, with MixColumns omitted in the final round. Round keys come from the shared key-schedule block through a request/valid handshake indexed by round number.

Parameters:
NR_DEFAULT, 10, Nr used when the nr input is 0 at start.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
start  input  1  begin encryption; sampled only in IDLE
nr  input  4  round count: 10, 12, 14, or 0 to select NR_DEFAULT
plain_in  input  [0:127]  plaintext, FIPS-197 byte order (byte0 = bits 0:7, column-major)
round_key  input  [0:127]  round key for round_idx
round_key_valid  input  1  round_key is valid for the current round_idx
key_req  output  1  core requests the key for round_idx
round_idx  output  4  current round number 0..Nr
busy  output  1  encryption in progress
done  output  1  one-cycle pulse; cipher_out valid
err  output  1  one-cycle pulse on start with illegal nr
cipher_out  output  [0:127]  ciphertext, held until the next accepted start

Behaviour:
- One clock; reset is asynchronous and active-low. Asserting rst at any time, including mid-operation, forces state=IDLE and sets all outputs and internal registers to 0: key_req, round_idx, busy, done, err, cipher_out, and the internal state register.
- FSM states: IDLE, ARK, SB, DONE.
- IDLE: on start with effective nr in {10,12,14}, capture plain_in into the state register, latch nr, set round_idx=0 and busy=1, and go to ARK. On start with any other nr, pulse err for 1 cycle and stay in IDLE.
- ARK: key_req=1. Stall while round_key_valid=0, holding state, round_idx and key_req.
  - When round_key_valid=1: round 0 uses state^key; rounds 1..Nr-1 use MixColumns(state)^key; round Nr uses state^key.
  - If round_idx==Nr, load the result into cipher_out and go to DONE. Otherwise increment round_idx and go to SB.
- SB: key_req=0. state <= ShiftRows(SubBytes(state)), 1 cycle, then go to ARK.
- DONE: done=1 and busy=0 for exactly 1 cycle, then go to IDLE.
- Latency with round_key_valid held high: done is high 2*Nr+2 cycles after the start-sampling edge (22 cycles for Nr=10, 30 for Nr=14). Each stall cycle adds exactly 1 cycle.
- start while busy or in DONE is ignored, with no err.
- cipher_out is unchanged from the accepted start until the final ARK edge.
- MixColumns uses GF(2^8) polynomial 0x11B with the matrix [02 03 01 01] rotated per row. The S-box is the FIPS-197 forward S-box.
- round_key is sampled only in a cycle where key_req && round_key_valid. round_key_valid without key_req is ignored.

Optional Feature:
AES_ENC_SBOX_PIPE_EN: when defined, SB takes 2 cycles. The S-box output is registered before ShiftRows, and key_req stays 0 through both SB cycles. Latency becomes 3*Nr+2 cycles (32 for Nr=10). When undefined, SB is a single cycle as above. Results are identical in both builds.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f (bench supplies the expanded keys), nr=10, plain 00112233445566778899aabbccddeeff -> cipher_out 69c4e0d86a7b0430d8cdb78070b4c55a, done 22 cycles after start, busy low after done.
- FIPS-197 C.3: key 000102...1e1f, nr=14, same plaintext -> 8ea2b7ca516745bfeafc49904b496089, done at cycle 30. With nr=0 and NR_DEFAULT=10, the C.1 vector passes.
- Key stall: in the C.1 run, drop round_key_valid for 3 cycles while round_idx=5 -> round_idx and key_req hold, done arrives at cycle 25, ciphertext unchanged.
- Illegal nr: start with nr=11 -> err=1 for one cycle, busy stays 0, key_req never asserts. A following legal start runs normally.
- Reset mid-op: assert rst while round_idx=4 -> all outputs 0 immediately. Release rst and rerun C.1 -> correct result at cycle 22.
- start pulsed during busy with a different plain_in -> ignored; the original ciphertext is produced and the error output does not fire.
